pe_acc_packer: RTL
==================

# pe_acc_packer

Downstream stage of the three-tap `pe` row. Consumes the three 17-bit partial sums (one per kernel row) produced in lockstep, forms the 3x3 convolution result, adds bias, requantizes to 8 bits and packs four pixels per 32-bit AXI4-Stream word toward the S2MM DMA channel. A small output FIFO absorbs stream backpressure, because the `pe` array has no stall input.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: output FIFO depth in 32-bit words; power of two, at least 4.
- `OUT_PIXELS`, 256: pixels per frame; multiple of 4. `m_axis_tlast` marks the word holding the last pixel.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, **asynchronous, active-low**.
- `i_o0`, `i_o1`, `i_o2`  in  17 each  partial sums from the three `pe`, two's complement.
- `i_valid`  in  3  per-`pe` valid; bit k belongs to `i_ok`.
- `bias`  in  8  signed bias; quasi-static, sampled every accepted pixel.
- `shift`  in  4  arithmetic right-shift amount, 0..15; quasi-static.
- `m_axis_tdata`  out  32  packed pixels; pixel n of the word is in bits [8n+7:8n].
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  frame end.
- `overflow`  out  1  sticky; set when a word is dropped because the FIFO is full.
- `err_align`  out  1  sticky; set when `i_valid` is neither 3'b000 nor 3'b111.

## Operation
- **Accept rule.** A pixel is accepted only when `i_valid == 3'b111`.
  - Any other non-zero value discards the inputs and sets `err_align`.
  - Sticky flags clear only on reset.
- **Stage 1 (S1).** `sum = sx(i_o0) + sx(i_o1) + sx(i_o2) + sx(bias)`, where `sx()` sign-extends to 20 bits. 20 bits is exact, with no overflow.
- **Stage 2 (S2).** `q = sum >>> shift` (arithmetic), then saturate per the Configuration section.
- **Packer.**
  - A 2-bit lane counter places `q` into byte lane `lane`, starting at 0.
  - On lane 3 the assembled word is written to the FIFO.
  - The write carries `tlast = (pix_cnt == OUT_PIXELS-1)`.
  - `pix_cnt` counts accepted pixels from 0 to OUT_PIXELS-1 and wraps to 0.
- **FIFO full on write.** The word is dropped and `overflow` is set. The lane and pixel counters still advance, so frame alignment is kept.
- **FIFO.** Registered-output, show-ahead. A word is popped when `m_axis_tvalid && m_axis_tready`.
- **Simultaneous push and pop when full.** The push succeeds, with no overflow.
- **AXI rule.** While `m_axis_tvalid` is high and `tready` is low, `tdata` and `tlast` hold stable.
- **Reset mid-operation.** Pipeline valids, lane counter, `pix_cnt`, FIFO pointers and flags are cleared. Any partial word is discarded.

## Timing
- Input accepted in cycle N:
  - S1 register valid in N+1.
  - S2 register valid in N+2.
- The 4th pixel of a word accepted in N is written at the end of N+2. `m_axis_tvalid` rises in N+3.
- Sustained throughput: one pixel per cycle in, one word per 4 cycles out. The FIFO never fills if `tready` duty is at least 25%.
- Reset values:
  - `m_axis_tvalid` = 0
  - `m_axis_tdata` = 0
  - `m_axis_tlast` = 0
  - `overflow` = 0
  - `err_align` = 0

## Configuration
- `PE_ACC_RELU_EN` defined:
  - Negative `sum` gives 0.
  - Result saturates to the unsigned range 0..255.
- Undefined:
  - No ReLU.
  - Result saturates to the signed range -128..127 and is packed as a two's-complement byte.

## Structure
- Package `pe_acc_pkg`:
  - Constants `PSUM_W=17`, `ACC_W=20`, `PIX_W=8`, `WORD_W=32`, `LANES=4`.
  - Typedef `acc_t` for the signed 20-bit accumulator.
  - Saturation bounds for both configuration modes.
- Sub-module `acc_fifo`: synchronous FIFO of `FIFO_DEPTH` x 33 bits (data plus tlast), with full/empty flags and a registered show-ahead output.

## Test plan
- Inputs 100, 50, -30, bias 8, shift 2 (sum 128):
  - With ReLU: lane byte 0x20.
  - Without ReLU: also 0x20.
- Inputs -500, 0, 0, bias 0, shift 2:
  - With ReLU: 0x00.
  - Without ReLU: 0x83 (-125).
- Inputs 40000 x3, shift 0:
  - With ReLU: 0xFF.
  - Without ReLU: 0x7F.
- Pixels 1,2,3,4 back-to-back with shift 0, bias 0, `tready` = 1:
  - One word `32'h04030201`.
  - `tvalid` high exactly 3 cycles after the 4th pixel is accepted.
- `OUT_PIXELS` = 8, 16 pixels, `tready` = 1:
  - 4 words, `tlast` on words 2 and 4.
- `tready` = 0 while (`FIFO_DEPTH`+1)x4 pixels stream:
  - `FIFO_DEPTH` words retained, `overflow` = 1.
  - After release, the words drain in order with stable data.
  - Separately, `i_valid` = 3'b011 sets `err_align` and emits nothing.

Source files
------------

// File: rtl/pe_acc_pkg.sv
// Shared widths, accumulator type and saturation helper for the pe_acc_packer slice.
// Saturation mode follows PE_ACC_RELU_EN (unsigned ReLU range when defined, signed range otherwise).
package pe_acc_pkg;

   localparam int PSUM_W = 17;
   localparam int ACC_W  = 20;
   localparam int PIX_W  = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef logic signed [ACC_W-1:0] acc_t;

   localparam acc_t RELU_MIN = acc_t'(0);
   localparam acc_t RELU_MAX = acc_t'(255);
   localparam acc_t SGN_MIN  = acc_t'(-128);
   localparam acc_t SGN_MAX  = acc_t'(127);

   // Clamp a shifted accumulator into one output byte for the active mode.
   function automatic logic [PIX_W-1:0] sat_pix(input acc_t v);
      logic [PIX_W-1:0] res;
`ifdef PE_ACC_RELU_EN
      if (v < RELU_MIN)
         res = '0;
      else if (v > RELU_MAX)
         res = 8'hFF;
      else
         res = v[PIX_W-1:0];
`else
      if (v < SGN_MIN)
         res = 8'h80;
      else if (v > SGN_MAX)
         res = 8'h7F;
      else
         res = v[PIX_W-1:0];
`endif
      return res;
   endfunction

endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO with a registered show-ahead head word; a push into a full
// FIFO is refused (drop_o) unless a pop happens in the same cycle.
module acc_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 33
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          pop_ok, push_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign drop_o  = push_i && !push_ok;
   assign rdata_o = head_q;

   // The head register always shows the oldest word; a write into an empty
   // (or just-emptied) FIFO bypasses the memory so it appears one cycle later.
   always_comb begin
      head_d   = head_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (count_q > (AW+1)'(1))
            head_d = mem[rd_ptr_q + 1'b1];
         else if (push_ok)
            head_d = wdata_i;
      end else if (empty_o && push_ok) begin
         head_d = wdata_i;
      end
      if (push_ok)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_ok && !pop_ok)
         count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/pe_acc_packer.sv
// Sums the three pe partial sums plus bias, requantizes to bytes and packs four
// per AXI4-Stream word through a small FIFO. Optional ReLU mode: PE_ACC_RELU_EN.
module pe_acc_packer
   import pe_acc_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int OUT_PIXELS = 256
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [PSUM_W-1:0] i_o0,
   input  logic [PSUM_W-1:0] i_o1,
   input  logic [PSUM_W-1:0] i_o2,
   input  logic [2:0]        i_valid,
   input  logic [PIX_W-1:0]  bias,
   input  logic [3:0]        shift,
   output logic [WORD_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              overflow,
   output logic              err_align
);

   localparam int PCW = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

   logic              accept, misalign;
   acc_t              sum_d, s1_sum_q, shifted;
   logic              s1_valid_q, s2_valid_q;
   logic [PIX_W-1:0]  s2_pix_q;
   logic [1:0]        lane_q;
   logic [PCW-1:0]    pix_cnt_q;
   logic [23:0]       word_q;
   logic              last_pix, push, drop, fifo_empty, fifo_full;
   logic [WORD_W:0]   fifo_wdata, fifo_rdata;
   logic              overflow_q, err_align_q;

   assign accept   = (i_valid == 3'b111);
   assign misalign = (i_valid != 3'b000) && !accept;
   assign sum_d    = acc_t'($signed(i_o0)) + acc_t'($signed(i_o1))
                   + acc_t'($signed(i_o2)) + acc_t'($signed(bias));
   assign shifted  = s1_sum_q >>> shift;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_pix_q   <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept)
            s1_sum_q <= sum_d;
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q)
            s2_pix_q <= sat_pix(shifted);
      end
   end

   assign last_pix   = (pix_cnt_q == PCW'(OUT_PIXELS-1));
   assign push       = s2_valid_q && (lane_q == 2'd3);
   assign fifo_wdata = {last_pix, s2_pix_q, word_q};

   // Lane and pixel counters advance even when the word is dropped, so the
   // tlast position stays locked to the frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane_q    <= '0;
         pix_cnt_q <= '0;
         word_q    <= '0;
      end else if (s2_valid_q) begin
         case (lane_q)
            2'd0:    word_q[7:0]   <= s2_pix_q;
            2'd1:    word_q[15:8]  <= s2_pix_q;
            2'd2:    word_q[23:16] <= s2_pix_q;
            default: word_q        <= word_q;
         endcase
         lane_q    <= lane_q + 2'd1;
         pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow_q  <= 1'b0;
         err_align_q <= 1'b0;
      end else begin
         if (drop)
            overflow_q <= 1'b1;
         if (misalign)
            err_align_q <= 1'b1;
      end
   end

   acc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (WORD_W+1)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (m_axis_tready),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .drop_o  (drop)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_rdata[WORD_W-1:0];
   assign m_axis_tlast  = fifo_rdata[WORD_W];
   assign overflow      = overflow_q;
   assign err_align     = err_align_q;

endmodule
